// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of predicted branches, resolved against execute outcomes.
// Ports: clock/reset (async, active-high); push_* from fetch; resolve_* from execute;
// upd_* to the predictor write port; flush/redirect_pc back to fetch;
// occupancy/empty/full/err_underflow status; stat_branches/stat_mispredicts saturating counters.
module branch_resolve_queue #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FALLTHRU_OFFSET = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  push_pred_taken,
  input  logic [ADDR_WIDTH-1:0] push_pred_target,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  output logic                  upd_valid,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic                  upd_taken,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  empty,
  output logic                  full,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  stat_branches,
  output logic [CNT_WIDTH-1:0]  stat_mispredicts
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0] pt_mem;
  logic [DEPTH_LOG2-1:0] rd, wr;
  logic push_ok, res_ok, mis;
  logic [ADDR_WIDTH-1:0] head_pc;
  assign empty = occupancy == '0;
  assign full = occupancy == (DEPTH_LOG2+1)'(DEPTH);
  assign push_ready = !full;
  assign push_ok = push_valid && !full;
  assign res_ok = resolve_valid && !empty;
  assign head_pc = pc_mem[rd];
  assign mis = (pt_mem[rd] != resolve_taken) || (resolve_taken && tgt_mem[rd] != resolve_target);
  always_ff @(posedge clock)
    if (push_ok) begin
      pc_mem[wr] <= push_pc;
      tgt_mem[wr] <= push_pred_target;
      pt_mem[wr] <= push_pred_taken;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      occupancy <= '0;
      upd_valid <= 1'b0;
      upd_pc <= '0;
      upd_taken <= 1'b0;
      flush <= 1'b0;
      redirect_pc <= '0;
      err_underflow <= 1'b0;
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      upd_valid <= res_ok;
      flush <= res_ok && mis;
      err_underflow <= err_underflow || (resolve_valid && empty);
      if (res_ok) begin
        upd_pc <= head_pc;
        upd_taken <= resolve_taken;
        stat_branches <= &stat_branches ? stat_branches : stat_branches + 1'b1;
      end
      if (res_ok && mis) begin
        redirect_pc <= resolve_taken ? resolve_target : head_pc + ADDR_WIDTH'(FALLTHRU_OFFSET);
        stat_mispredicts <= &stat_mispredicts ? stat_mispredicts : stat_mispredicts + 1'b1;
        // Wrong-path entries (and any same-cycle push) are dropped by collapsing both pointers past the head.
        rd <= rd + 1'b1;
        wr <= rd + 1'b1;
        occupancy <= '0;
      end else begin
        if (push_ok) wr <= wr + 1'b1;
        if (res_ok) rd <= rd + 1'b1;
        occupancy <= occupancy + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(res_ok);
      end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and random stimulus against a queue-based reference model.
module tb_branch_resolve_queue;
  logic clock = 0, reset = 1;
  logic push_valid = 0, push_ready, push_pred_taken = 0;
  logic [31:0] push_pc = 0, push_pred_target = 0;
  logic resolve_valid = 0, resolve_taken = 0;
  logic [31:0] resolve_target = 0;
  logic upd_valid, upd_taken, flush, empty, full, err_underflow;
  logic [31:0] upd_pc, redirect_pc;
  logic [2:0] occupancy;
  logic [3:0] stat_branches, stat_mispredicts;
  typedef struct {logic [31:0] pc; logic pt; logic [31:0] tgt;} ent_t;
  ent_t q[$];
  int vectors = 0, errs = 0;
  logic e_uv = 0, e_ut = 0, e_fl = 0, e_err = 0;
  logic [31:0] e_upc = 0, e_rpc = 0;
  logic [3:0] e_sb = 0, e_sm = 0;
  branch_resolve_queue #(.DEPTH_LOG2(2), .ADDR_WIDTH(32), .FALLTHRU_OFFSET(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .occupancy(occupancy),
    .empty(empty), .full(full), .err_underflow(err_underflow),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] sat(input logic [3:0] x);
    return x == 4'hf ? x : x + 4'h1;
  endfunction
  task automatic check_all();
    chk("upd_valid", upd_valid, e_uv);
    if (e_uv) begin
      chk("upd_pc", upd_pc, e_upc);
      chk("upd_taken", upd_taken, e_ut);
    end
    chk("flush", flush, e_fl);
    if (e_fl) chk("redirect_pc", redirect_pc, e_rpc);
    chk("occupancy", occupancy, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == 4);
    chk("push_ready", push_ready, q.size() != 4);
    chk("err_underflow", err_underflow, e_err);
    chk("stat_branches", stat_branches, e_sb);
    chk("stat_mispredicts", stat_mispredicts, e_sm);
  endtask
  task automatic step(input logic pv, input logic [31:0] ppc, input logic ppt, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    ent_t h;
    logic pa, ra, mis;
    push_valid = pv; push_pc = ppc; push_pred_taken = ppt; push_pred_target = ptg;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
    pa = pv && q.size() < 4;
    ra = rv && q.size() > 0;
    mis = 0;
    @(posedge clock); #1;
    e_uv = ra;
    e_fl = 0;
    if (rv && !ra) e_err = 1;
    if (ra) begin
      h = q.pop_front();
      mis = (h.pt != rt) || (rt && h.tgt != rtg);
      e_upc = h.pc;
      e_ut = rt;
      e_fl = mis;
      e_sb = sat(e_sb);
      if (mis) begin
        e_rpc = rt ? rtg : h.pc + 32'd4;
        e_sm = sat(e_sm);
        q.delete();
      end
    end
    if (pa && !mis) q.push_back('{ppc, ppt, ptg});
    check_all();
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    step(1, pc, pt, tg, 0, 0, 0);
  endtask
  task automatic resolve(input logic rt, input logic [31:0] tg);
    step(0, 0, 0, 0, 1, rt, tg);
  endtask
  initial begin
    #2;
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_underflow, 0);
    #10 reset = 0;
    push(32'h100, 1, 32'h200);
    resolve(1, 32'h200);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_flush", flush, 0);
    push(32'h100, 0, 32'h0);
    resolve(1, 32'h300);
    chk("t2_redirect", redirect_pc, 32'h300);
    chk("t2_mispredicts", stat_mispredicts, 1);
    push(32'h100, 1, 32'h200);
    push(32'h104, 1, 32'h200);
    push(32'h108, 1, 32'h200);
    resolve(0, 32'h0);
    chk("t3_redirect", redirect_pc, 32'h104);
    chk("t3_occ", occupancy, 0);
    resolve(0, 32'h0);
    chk("t3_err", err_underflow, 1);
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i) * 4, 0, 0);
    chk("t4_full", full, 1);
    for (int i = 0; i < 6; i++) step(1, 32'h500 + 32'(i) * 4, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) resolve(0, 0);
    step(1, 32'h600, 1, 32'h700, 1, 1, 32'h700);
    chk("t5_upd_valid", upd_valid, 0);
    chk("t5_occ", occupancy, 1);
    push(32'h604, 1, 32'h700);
    push(32'h608, 1, 32'h700);
    resolve(1, 32'h700);
    resolve_valid = 1;
    #2 reset = 1;
    #1;
    q.delete();
    e_uv = 0; e_fl = 0; e_err = 0; e_sb = 0; e_sm = 0; e_upc = 0; e_rpc = 0; e_ut = 0;
    chk("t6_upd_valid", upd_valid, 0);
    chk("t6_upd_pc", upd_pc, 0);
    chk("t6_empty", empty, 1);
    check_all();
    resolve_valid = 0;
    @(posedge clock); #1 reset = 0;
    idle();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ptg, rtg;
      ptg = $urandom_range(0, 1) ? 32'h200 : 32'h300;
      rtg = $urandom_range(0, 3) != 0 ? ptg : 32'h380;
      step($urandom_range(0, 9) < 6, {$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)), ptg,
           $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)), rtg);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
